// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, ASID-tagged instruction cache sitting behind
// the fetch0 read-request interface. Hits answer one cycle after the request;
// misses stall fetch, refill the whole line in order and replay the requested word.
// Optional hit/miss counters are compiled in when ICACHE_PERF_EN is defined.
module icache_responder #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                                   clk_core,
    input  logic                                   reset,
    input  logic                                   fe0_read_req,
    input  logic [8:0]                             fe0_read_asid,
    input  logic [29:0]                            fe0_read_addr,
    input  logic                                   ic_flush,
    output logic                                   ic_valid,
    output logic [31:0]                            ic_data,
    output logic [29:0]                            ic_addr,
    output logic                                   ic_stall,
    output logic                                   mem_req,
    output logic [31-$clog2(LINE_WORDS*4):0]       mem_addr,
    input  logic                                   mem_gnt,
    input  logic                                   mem_rvalid,
    input  logic [31:0]                            mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                            ic_hit_count,
    output logic [31:0]                            ic_miss_count
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int UPR_W = 30 - OFF_W - IDX_W;
    localparam int TAG_W = 9 + UPR_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                stage_vld_q;
    logic [29:0]         addr_q;
    logic [8:0]          asid_q;
    logic [LINES-1:0]    valid_q;
    logic [OFF_W-1:0]    cnt_q;
    logic [31:0]         replay_q;
    logic                flush_pend_q;

    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*LINE_WORDS];
    logic [TAG_W-1:0]    tag_rd_q;
    logic [31:0]         data_rd_q;

    // Request-side and stage-side address fields.
    logic [IDX_W-1:0]    req_idx, idx_q;
    logic [OFF_W-1:0]    req_off, off_q;
    logic [TAG_W-1:0]    tag_q;
    logic                accept, lookup, hit, miss, beat, last_beat;

    assign req_idx   = fe0_read_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_off   = fe0_read_addr[OFF_W-1:0];
    assign idx_q     = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign off_q     = addr_q[OFF_W-1:0];
    assign tag_q     = {asid_q, addr_q[29:OFF_W+IDX_W]};

    assign accept    = fe0_read_req && !ic_stall;
    assign lookup    = stage_vld_q && (state_q == S_IDLE);
    // A flush in the compare cycle forces a miss even if the line was valid.
    assign hit       = lookup && valid_q[idx_q] && (tag_rd_q == tag_q) && !ic_flush;
    assign miss      = lookup && !hit;
    assign beat      = (state_q == S_FILL) && mem_rvalid;
    assign last_beat = beat && (cnt_q == LAST_BEAT);
    assign mem_addr  = addr_q[29:OFF_W];

    // Next-state and output decode for the lookup/refill FSM.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d  = state_q;
        ic_valid = 1'b0;
        ic_data  = '0;
        ic_addr  = '0;
        ic_stall = 1'b0;
        mem_req  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hit) begin
                    ic_valid = 1'b1;
                    ic_data  = data_rd_q;
                    ic_addr  = addr_q;
                end else if (miss) begin
                    ic_stall = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                ic_stall = 1'b1;
                mem_req  = 1'b1;
                if (mem_gnt) state_d = S_FILL;
            end
            S_FILL: begin
                ic_stall = 1'b1;
                if (last_beat) state_d = S_DONE;
            end
            S_DONE: begin
                ic_valid = 1'b1;
                ic_data  = replay_q;
                ic_addr  = addr_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state: FSM, stage register, valid bits, beat counter, replay word.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q      <= S_IDLE;
            stage_vld_q  <= 1'b0;
            addr_q       <= '0;
            asid_q       <= '0;
            valid_q      <= '0;
            cnt_q        <= '0;
            replay_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_vld_q <= accept;
            if (accept) begin
                addr_q <= fe0_read_addr;
                asid_q <= fe0_read_asid;
            end
            if (state_q == S_REQ && mem_gnt) cnt_q <= '0;
            else if (beat)                   cnt_q <= cnt_q + OFF_W'(1);
            if (beat && cnt_q == off_q) replay_q <= mem_rdata;
            // A flush seen while the refill is outstanding keeps that line invalid.
            if (miss)
                flush_pend_q <= 1'b0;
            else if (ic_flush && (state_q == S_REQ || state_q == S_FILL))
                flush_pend_q <= 1'b1;
            // Flush wins over a coincident valid-set on the last beat.
            if (ic_flush)
                valid_q <= '0;
            else if (last_beat && !flush_pend_q)
                valid_q[idx_q] <= 1'b1;
        end
    end

    // Tag and data arrays: synchronous read on accept, refill writes.
    always_ff @(posedge clk_core) begin
        // NOTE: array contents are not reset; the valid bits alone decide whether a line is usable.
        if (accept) begin
            tag_rd_q  <= tag_mem[req_idx];
            data_rd_q <= data_mem[{req_idx, req_off}];
        end
        if (beat)      data_mem[{idx_q, cnt_q}] <= mem_rdata;
        if (last_beat) tag_mem[idx_q]           <= tag_q;
    end

`ifdef ICACHE_PERF_EN
    // Free-running hit and miss counters, wrapping at 2^32.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            ic_hit_count  <= '0;
            ic_miss_count <= '0;
        end else begin
            if (hit)  ic_hit_count  <= ic_hit_count + 32'd1;
            if (miss) ic_miss_count <= ic_miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed scenarios plus randomized traffic against a
// line-level cache model; responses are checked by a scoreboard monitor.
module tb_icache_responder;

    logic        clk_core = 1'b0;
    logic        reset;
    logic        fe0_read_req;
    logic [8:0]  fe0_read_asid;
    logic [29:0] fe0_read_addr;
    logic        ic_flush;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic [29:0] ic_addr;
    logic        ic_stall;
    logic        mem_req;
    logic [27:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk_core = ~clk_core;

    icache_responder dut (
        .clk_core      (clk_core),
        .reset         (reset),
        .fe0_read_req  (fe0_read_req),
        .fe0_read_asid (fe0_read_asid),
        .fe0_read_addr (fe0_read_addr),
        .ic_flush      (ic_flush),
        .ic_valid      (ic_valid),
        .ic_data       (ic_data),
        .ic_addr       (ic_addr),
        .ic_stall      (ic_stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } resp_t;
    resp_t sb[$];

    // Reference model: which lines hold which tag, and the words they hold.
    bit          mv    [64];
    logic [30:0] mtag  [64];
    logic [31:0] mdata [64][4];
    int unsigned fill_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory content: distinct per line, beat and refill number.
    function automatic logic [31:0] fill_word(input logic [27:0] line, input int beat, input int unsigned n);
        return (n * 32'h0100_0193) ^ {line, 4'h0} ^ 32'(beat) ^ 32'hA500_0000;
    endfunction

    function automatic bit model_hit(input logic [29:0] a, input logic [8:0] s);
        return mv[a[7:2]] && (mtag[a[7:2]] == {s, a[29:8]});
    endfunction

    function automatic void model_flush();
        foreach (mv[i]) mv[i] = 1'b0;
    endfunction

    // Scoreboard monitor: every response must match the oldest expected one.
    always @(negedge clk_core) begin
        resp_t r;
        if (!reset && ic_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got addr %h data %h with nothing expected", ic_addr, ic_data);
            end else begin
                r = sb.pop_front();
                check("resp_addr", 32'(ic_addr), 32'(r.addr));
                check("resp_data", ic_data, r.data);
            end
        end
    end

    // One request; on a miss, act as the memory and refill the line.
    task automatic access(input logic [29:0] a, input logic [8:0] s, input int gnt_dly,
                          input int flush_beat, input bit flush_lookup);
        logic [5:0]  idx;
        logic [1:0]  off;
        logic [27:0] line;
        bit          hit;
        bit          flushed;
        int unsigned n;
        resp_t       r;
        idx = a[7:2];
        off = a[1:0];
        line = a[29:2];
        fe0_read_req  = 1'b1;
        fe0_read_addr = a;
        fe0_read_asid = s;
        @(posedge clk_core); #1;
        fe0_read_req = 1'b0;
        ic_flush = flush_lookup;
        #1;
        hit = !flush_lookup && model_hit(a, s);
        if (flush_lookup) model_flush();
        check("lookup_stall", 32'(ic_stall), 32'(!hit));
        r.addr = a;
        if (hit) begin
            r.data = mdata[idx][off];
            sb.push_back(r);
            @(posedge clk_core); #1;
            ic_flush = 1'b0;
        end else begin
            n = fill_no;
            fill_no++;
            flushed = 1'b0;
            r.data = fill_word(line, int'(off), n);
            sb.push_back(r);
            @(posedge clk_core); #1;
            ic_flush = 1'b0;
            for (int i = 0; i < gnt_dly; i++) begin
                check("req_held", 32'(mem_req), 32'd1);
                @(posedge clk_core); #1;
            end
            mem_gnt = 1'b1;
            check("req_at_gnt", 32'(mem_req), 32'd1);
            check("req_line", 32'(mem_addr), 32'(line));
            @(posedge clk_core); #1;
            mem_gnt = 1'b0;
            check("req_drop", 32'(mem_req), 32'd0);
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk_core); #1;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = fill_word(line, b, n);
                mdata[idx][b] = mem_rdata;
                if (b == flush_beat) begin
                    ic_flush = 1'b1;
                    flushed  = 1'b1;
                end
                @(posedge clk_core); #1;
                mem_rvalid = 1'b0;
                ic_flush   = 1'b0;
            end
            check("done_stall", 32'(ic_stall), 32'd0);
            if (flushed) begin
                model_flush();
            end else begin
                mv[idx]   = 1'b1;
                mtag[idx] = {s, a[29:8]};
            end
            @(posedge clk_core); #1;
        end
    endtask

    // Consecutive requests that the caller knows will all hit.
    task automatic stream(input logic [29:0] base, input int n, input logic [8:0] s);
        logic [29:0] a;
        resp_t       r;
        for (int i = 0; i < n; i++) begin
            a = base + 30'(i);
            fe0_read_req  = 1'b1;
            fe0_read_addr = a;
            fe0_read_asid = s;
            r.addr = a;
            r.data = mdata[a[7:2]][a[1:0]];
            sb.push_back(r);
            @(posedge clk_core); #1;
            check("stream_stall", 32'(ic_stall), 32'd0);
            check("stream_memreq", 32'(mem_req), 32'd0);
        end
        fe0_read_req = 1'b0;
        @(posedge clk_core); #1;
    endtask

    // Reset arriving after two fill beats; the rest of the line is dropped.
    task automatic reset_mid_fill(input logic [29:0] a, input logic [8:0] s);
        logic [27:0] line;
        int unsigned n;
        line = a[29:2];
        ic_flush = 1'b1;
        model_flush();
        @(posedge clk_core); #1;
        ic_flush = 1'b0;
        fe0_read_req  = 1'b1;
        fe0_read_addr = a;
        fe0_read_asid = s;
        @(posedge clk_core); #1;
        fe0_read_req = 1'b0;
        check("rst_lookup_stall", 32'(ic_stall), 32'd1);
        @(posedge clk_core); #1;
        mem_gnt = 1'b1;
        @(posedge clk_core); #1;
        mem_gnt = 1'b0;
        n = fill_no;
        fill_no++;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = fill_word(line, b, n);
            @(posedge clk_core); #1;
        end
        mem_rvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk_core); #1;
        check("rst_valid", 32'(ic_valid), 32'd0);
        check("rst_stall", 32'(ic_stall), 32'd0);
        check("rst_memreq", 32'(mem_req), 32'd0);
        check("rst_data", ic_data, 32'd0);
        check("rst_addr", 32'(ic_addr), 32'd0);
        reset = 1'b0;
        model_flush();
        for (int b = 2; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = fill_word(line, b, n);
            @(posedge clk_core); #1;
        end
        mem_rvalid = 1'b0;
        check("rst_beats_ignored_stall", 32'(ic_stall), 32'd0);
        check("rst_beats_ignored_req", 32'(mem_req), 32'd0);
        access(a, s, 1, -1, 1'b0);
    endtask

    initial begin
        logic [29:0] a;
        logic [8:0]  s;
        int          fb;
        reset         = 1'b1;
        fe0_read_req  = 1'b0;
        fe0_read_asid = '0;
        fe0_read_addr = '0;
        ic_flush      = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        model_flush();
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        check("reset_valid", 32'(ic_valid), 32'd0);
        check("reset_stall", 32'(ic_stall), 32'd0);
        check("reset_memreq", 32'(mem_req), 32'd0);
        check("reset_data", ic_data, 32'd0);
        check("reset_addr", 32'(ic_addr), 32'd0);
        @(posedge clk_core); #1;
        reset = 1'b0;
        @(posedge clk_core); #1;

        // Cold miss on byte address 0x1000, then a hit stream over the line.
        access(30'h400, 9'd0, 2, -1, 1'b0);
        stream(30'h401, 3, 9'd0);
        // Critical word at offset 3 with a slow grant.
        access(30'h0C0B, 9'd0, 5, -1, 1'b0);
        // ASID aliasing and eviction at the same index.
        access(30'h400, 9'd1, 0, -1, 1'b0);
        access(30'h400, 9'd2, 1, -1, 1'b0);
        access(30'h400, 9'd1, 0, -1, 1'b0);
        access(30'h400, 9'd1, 0, -1, 1'b0);
        // Flush during beat 1, then the same address misses again.
        access(30'h500, 9'd3, 1, 1, 1'b0);
        access(30'h500, 9'd3, 0, -1, 1'b0);
        // Flush coincident with the compare forces a miss on a valid line.
        access(30'h500, 9'd3, 0, -1, 1'b1);
        access(30'h500, 9'd3, 0, -1, 1'b0);
        // Flush on the last beat.
        access(30'h604, 9'd5, 0, 3, 1'b0);
        access(30'h604, 9'd5, 0, -1, 1'b0);
        reset_mid_fill(30'h604, 9'd4);

        // Randomized traffic over a few indices, tags and ASIDs.
        for (int i = 0; i < 200; i++) begin
            a = {22'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            s = 9'($urandom_range(0, 1));
            fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (model_hit(a, s) && a[1:0] == 2'd0 && $urandom_range(0, 1) == 1)
                stream(a, 4, s);
            else
                access(a, s, int'($urandom_range(0, 3)), fb, $urandom_range(0, 15) == 0);
        end

        repeat (3) @(posedge clk_core);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder on the other end of the fetch0 read-request interface.
- Accepts fe0 read requests (req/asid/word address), returns the instruction word to fetch1 one cycle later on a hit.
- On a miss: asserts stall, refills a line from the memory bus, then replays the response.
- Direct-mapped cache, ASID-tagged, virtual address used as physical (no translation in this block).

Parameters:
- LINES, 64, number of cache lines (power of 2, >=2)
- LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
- clk_core  in  1  core clock
- reset  in  1  synchronous active-high reset
- fe0_read_req  in  1  read request from fetch0
- fe0_read_asid  in  9  ASID of request
- fe0_read_addr  in  30  word address [31:2]
- ic_flush  in  1  invalidate all lines (fence.i / satp write)
- ic_valid  out  1  response valid to fetch1
- ic_data  out  32  instruction word
- ic_addr  out  30  word address of response
- ic_stall  out  1  miss in progress; fetch1 ORs into fe1_stall
- mem_req  out  1  line-fill request
- mem_addr  out  32-log2(LINE_WORDS*4)  line address
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  fill beat valid
- mem_rdata  in  32  fill beat data

Behaviour:
- Interface: one clock (clk_core); reset is synchronous and active-high (reset).
- Index = addr[log2(LINE_WORDS)+log2(LINES)+1 : log2(LINE_WORDS)+2]; tag = {asid, remaining upper addr bits}.
- Storage: valid bits in flops; tag and data arrays with synchronous read.
- Reset values:
  - all valid bits 0, FSM IDLE
  - ic_valid=0, ic_stall=0, mem_req=0
  - ic_data, ic_addr = 0
  - Reset mid-fill abandons the fill; any remaining mem_rvalid beats are ignored.
- Stage register: on fe0_read_req with ic_stall=0, latch addr and asid; arrays are read the same cycle.
- Next cycle, tag compare:
  - hit: ic_valid=1, ic_data = the addressed word, ic_addr = the latched addr.
  - miss: ic_valid=0, ic_stall=1 starting that cycle, FSM -> REQ.
- Back-to-back hits: one response per cycle, no bubbles.
- fe0_read_req while ic_stall=1 is ignored; the fetch stages guarantee it is not asserted.
- FSM:
  - IDLE: as above.
  - REQ: mem_req=1, mem_addr = line address; hold until mem_gnt, then -> FILL with beat count 0.
  - FILL: each mem_rvalid writes the word at beat count into the data array and increments the count. The beat whose count equals the requested word offset is captured in a replay register. The last beat (count = LINE_WORDS-1) writes the tag, sets valid, -> DONE.
  - DONE: ic_valid=1 with the replay word and the latched addr; ic_stall=0; -> IDLE.
- Fill beats always arrive in order, word 0 first.
- Flush:
  - ic_flush clears all valid bits in one cycle.
  - Flush while IDLE, coincident with a stage-register compare: that compare is forced to a miss.
  - Flush during REQ/FILL: the fill completes but the line is not marked valid. The replay word is still returned in DONE.
- ic_flush coincident with a valid-set on the last fill beat: flush wins, line stays invalid.
- Aliasing: same index with a different tag evicts the old line unconditionally. A different ASID at the same address misses.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - adds outputs ic_hit_count [31:0] and ic_miss_count [31:0], reset to 0.
  - hit_count increments on each hit-path ic_valid; miss_count increments on each IDLE->REQ transition.
  - Both wrap modulo 2^32.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Cold miss: req addr 0x1000>>2, asid 0 -> ic_stall=1 next cycle; mem_req with line addr 0x100 held until gnt; 4 beats A0..A3 -> DONE ic_valid=1, ic_data=A0, ic_addr=0x400; ic_stall=0.
- Hit stream: after the fill above, reqs to words 0x401, 0x402, 0x403 on consecutive cycles -> ic_valid=1 on 3 consecutive cycles with data A1, A2, A3; mem_req stays 0.
- Critical word: miss on 0x0C0B (word offset 3), gnt delayed 5 cycles, beats D0..D3 -> replay data D3; mem_req stays high exactly until the gnt cycle.
- ASID/conflict: fill 0x400 with asid 1, then req 0x400 with asid 2 -> miss; req with asid 1 -> miss (evicted by the asid 2 fill).
- Flush mid-fill: ic_flush asserted during beat 1 -> replay word returned; an immediate re-request of the same address misses again.
- Reset during FILL after 2 beats -> all outputs 0 next cycle; the remaining beats are ignored; a re-request misses.
